// File: rtl/m6502_alu_seq_if.sv
// Request/result bundle between the m6502 sequencer and the sequenced ALU.
// The sequencer is the master; the ALU is the slave.
interface m6502_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             decimal;
  logic             flag_c_set;
  logic             flag_c_reset;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             flag_c;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;

  modport master (
    output start, op, in_a, in_b, decimal, flag_c_set, flag_c_reset,
    input  out, busy, done, flag_c, flag_z, flag_v, flag_n
  );

  modport slave (
    input  start, op, in_a, in_b, decimal, flag_c_set, flag_c_reset,
    output out, busy, done, flag_c, flag_z, flag_v, flag_n
  );
endinterface

// File: rtl/m6502_alu_seq.sv
// Handshaked, width-parametrised m6502 ALU with optional BCD adjust cycle.
// Owns the C, Z, V and N flags; results are registered on entry to DONE.
module m6502_alu_seq #(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  m6502_alu_seq_if.slave  bus
);
  localparam int M   = WIDTH - 1;
  localparam int NIB = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, EXEC, ADJUST, DONE} state_t;
  typedef enum logic [3:0] {
    OP_UPDATE, OP_AND, OP_OR, OP_EOR, OP_ADC, OP_SBC, OP_INC, OP_DEC,
    OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_BIT, OP_NOP0, OP_NOP1
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, out_q;
  logic             dec_q, cin_q, exec_ph;
  logic [WIDTH:0]   res_q;
  logic             c_q, z_q, v_q, n_q;
  logic             set_q, clr_q;

  logic             need_adj, commit;
  logic [WIDTH-1:0] bp, dec_r, r;
  logic             dec_c;
  logic [WIDTH:0]   bin_r, fin_r;
  logic             c_nx, z_nx, v_nx, n_nx;
  logic [5:0]       s;
  logic [3:0]       an, bn, dig;

  assign need_adj = DECIMAL_EN && dec_q && (op_q == OP_ADC || op_q == OP_SBC);

  // EXEC spans two cycles: the first registers the binary result, the second commits or hands off to ADJUST.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) state_d = EXEC;
      EXEC:    if (exec_ph) begin
                 state_d = need_adj ? ADJUST : DONE;
                 commit  = !need_adj;
               end
      ADJUST:  begin state_d = DONE; commit = 1'b1; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    bp = (op_q == OP_SBC) ? ~b_q : b_q;
    case (op_q)
      OP_AND:          bin_r = {1'b0, a_q & b_q};
      OP_OR:           bin_r = {1'b0, a_q | b_q};
      OP_EOR:          bin_r = {1'b0, a_q ^ b_q};
      OP_ADC, OP_SBC:  bin_r = {1'b0, a_q} + {1'b0, bp} + {{WIDTH{1'b0}}, cin_q};
      OP_INC:          bin_r = {1'b0, a_q + WIDTH'(1)};
      OP_DEC:          bin_r = {1'b0, a_q - WIDTH'(1)};
      OP_CMP:          bin_r = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
      OP_ASL:          bin_r = {a_q, 1'b0};
      OP_ROL:          bin_r = {a_q, cin_q};
      OP_LSR:          bin_r = {a_q[0], 1'b0, a_q[M:1]};
      OP_ROR:          bin_r = {a_q[0], cin_q, a_q[M:1]};
      default:         bin_r = {1'b0, a_q};
    endcase
  end

  // Nibble-serial BCD correction, carry/borrow rippling upward from the LSB digit.
  always_comb begin
    dec_r = '0;
    dec_c = cin_q;
    s     = '0;
    an    = '0;
    bn    = '0;
    dig   = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      an = a_q[i*4 +: 4];
      bn = b_q[i*4 +: 4];
      if (op_q == OP_SBC) begin
        s     = {2'b00, an} + {2'b00, ~bn} + {5'b0, dec_c};
        dec_c = s[4];
        dig   = dec_c ? s[3:0] : s[3:0] - 4'd6;
      end else begin
        s = {2'b00, an} + {2'b00, bn} + {5'b0, dec_c};
        if (s > 6'd9) s = s + 6'd6;
        dec_c = (s > 6'd15);
        dig   = s[3:0];
      end
      dec_r[i*4 +: 4] = dig;
    end
  end

  always_comb begin
    fin_r = (state_q == ADJUST) ? {dec_c, dec_r} : res_q;
    r     = fin_r[M:0];
    c_nx  = c_q;
    v_nx  = v_q;
    z_nx  = (r == '0);
    n_nx  = r[M];
    case (op_q)
      OP_ADC, OP_SBC: begin
        c_nx = fin_r[WIDTH];
        v_nx = ~(a_q[M] ^ bp[M]) & (a_q[M] ^ r[M]);
      end
      OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: c_nx = fin_r[WIDTH];
      OP_BIT: begin
        z_nx = ((a_q & b_q) == '0);
        n_nx = b_q[M];
        v_nx = b_q[M-1];
      end
      OP_NOP0, OP_NOP1: begin
        z_nx = z_q;
        n_nx = n_q;
        r    = out_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_UPDATE;
      a_q     <= '0;
      b_q     <= '0;
      dec_q   <= 1'b0;
      cin_q   <= 1'b0;
      exec_ph <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      set_q   <= bus.flag_c_set;
      clr_q   <= bus.flag_c_reset;
      exec_ph <= (state_q == EXEC) && !exec_ph;
      if (state_q == IDLE && bus.start) begin
        op_q  <= op_t'(bus.op);
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        dec_q <= bus.decimal & DECIMAL_EN;
        cin_q <= c_q;
      end
      if (state_q == EXEC && !exec_ph) res_q <= bin_r;
      if (commit) begin
        out_q <= r;
        z_q   <= z_nx;
        v_q   <= v_nx;
        n_q   <= n_nx;
      end
      if (bus.flag_c_set && !set_q)           c_q <= 1'b1;
      else if (bus.flag_c_reset && !clr_q)    c_q <= 1'b0;
      else if (commit)                        c_q <= c_nx;
    end
  end

  assign bus.out    = out_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.flag_c = c_q;
  assign bus.flag_z = z_q;
  assign bus.flag_v = v_q;
  assign bus.flag_n = n_q;
endmodule
